// File: rtl/pe_row_skewed.sv
// Weight-stationary PE row: double-buffered stationary weights, internal input skew,
// registered partial-sum chain, forwarded data and an optional result accumulator.
module pe_row_skewed #(
    parameter int WEIGHT_BW      = 8,
    parameter int DATA_BW        = 8,
    parameter int PARTIAL_SUM_BW = 19,
    parameter int MATRIX_SIZE    = 8,
    parameter int ACC_BW         = 32
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] WEIGHTS,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic [MATRIX_SIZE*DATA_BW-1:0]   DIN,
    input  logic                             acc_mode,
    input  logic                             acc_clr,
    output logic [MATRIX_SIZE*DATA_BW-1:0]   DF,
    output logic                             dout_valid,
    output logic signed [PARTIAL_SUM_BW-1:0] result,
    output logic signed [ACC_BW-1:0]         acc_out
);

    localparam int N  = MATRIX_SIZE;
    localparam int PW = WEIGHT_BW + DATA_BW;
    localparam int CW = $clog2(MATRIX_SIZE + 1);

    logic                             shadow_full_q, shadow_full_d;
    logic [N*WEIGHT_BW-1:0]           shadow_q;
    logic [N*WEIGHT_BW-1:0]           active_q;
    logic [CW-1:0]                    inflight_q, inflight_d;
    logic                             valid_in_q;
    logic [N-1:0]                     valid_q;
    logic signed [PARTIAL_SUM_BW-1:0] psum_q [N];
    logic signed [PARTIAL_SUM_BW-1:0] psum_d [N];
    logic [DATA_BW-1:0]               pe_data [N];
    logic [N*DATA_BW-1:0]             df_q;
    logic signed [ACC_BW-1:0]         acc_q, acc_d;
    logic signed [ACC_BW-1:0]         result_ext;

    logic accept;
    logic w_accept;
    logic swap;
    logic emit;

    assign w_ready   = ~shadow_full_q;
    assign din_ready = ~shadow_full_q;
    assign accept    = din_valid & ~shadow_full_q;
    assign w_accept  = w_valid & ~shadow_full_q;
    assign swap      = shadow_full_q & (inflight_q == '0);
    // emit marks the edge at which the last PE writes a valid result
    assign emit      = valid_q[N-2];

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int DLSB = (N - 1 - k) * DATA_BW;
        localparam int WLSB = (N - 1 - k) * WEIGHT_BW;

        logic [DATA_BW-1:0] dly_q [k+1];
        logic signed [PW-1:0] prod;

        // Lane k is held k+1 registers so it meets the psum arriving from PE k-1
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= k; j++) dly_q[j] <= '0;
            end else begin
                dly_q[0] <= accept ? DIN[DLSB +: DATA_BW] : '0;
                for (int j = 1; j <= k; j++) dly_q[j] <= dly_q[j-1];
            end
        end

        assign pe_data[k] = dly_q[k];
        assign prod = PW'($signed(dly_q[k])) * PW'($signed(active_q[WLSB +: WEIGHT_BW]));

        if (k == 0) begin : g_first
            assign psum_d[k] = PARTIAL_SUM_BW'(prod);
        end else begin : g_rest
            assign psum_d[k] = psum_q[k-1] + PARTIAL_SUM_BW'(prod);
        end
    end

    assign result_ext = ACC_BW'(psum_d[N-1]);

    always_comb begin
        shadow_full_d = shadow_full_q;
        if (w_accept) begin
            shadow_full_d = 1'b1;
        end else if (swap) begin
            shadow_full_d = 1'b0;
        end

        inflight_d = inflight_q;
        if (accept && !emit) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!accept && emit) begin
            inflight_d = inflight_q - CW'(1);
        end

        // A clear coinciding with a result restarts the sum from that result
        acc_d = acc_q;
        if (emit) begin
            acc_d = (acc_mode && !acc_clr) ? acc_q + result_ext : result_ext;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            inflight_q    <= '0;
            valid_in_q    <= 1'b0;
            valid_q       <= '0;
            df_q          <= '0;
            acc_q         <= '0;
            for (int k = 0; k < N; k++) psum_q[k] <= '0;
        end else begin
            shadow_full_q <= shadow_full_d;
            if (w_accept) shadow_q <= WEIGHTS;
            if (swap) active_q <= shadow_q;
            inflight_q <= inflight_d;
            valid_in_q <= accept;
            valid_q    <= {valid_q[N-2:0], valid_in_q};
            for (int k = 0; k < N; k++) begin
                psum_q[k] <= psum_d[k];
                df_q[(N-1-k)*DATA_BW +: DATA_BW] <= pe_data[k];
            end
            acc_q <= acc_d;
        end
    end

    assign DF         = df_q;
    assign dout_valid = valid_q[N-1];
    assign result     = psum_q[N-1];
    assign acc_out    = acc_q;

endmodule
